// File: rtl/alu_nbit_seq_if.sv
// alu_nbit_seq_if: operand/result handshake bundle for alu_nbit_seq.
// With ALU_FLAGS_EN defined, the bundle also carries the zero/ovf flags.
interface alu_nbit_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic             c_out;
  logic             busy;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             ovf;
  modport slave  (input in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, r, c_out, busy, zero, ovf);
  modport master (output in_valid, op, a, b, out_ready,
                  input in_ready, out_valid, r, c_out, busy, zero, ovf);
`else
  modport slave  (input in_valid, op, a, b, out_ready,
                  output in_ready, out_valid, r, c_out, busy);
  modport master (output in_valid, op, a, b, out_ready,
                  input in_ready, out_valid, r, c_out, busy);
`endif
endinterface

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: WIDTH-bit handshake ALU, single-cycle logic/arith ops, shift-add MUL.
// Optional ALU_FLAGS_EN adds registered zero/ovf result flags.
module alu_nbit_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_nbit_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef ALU_FLAGS_EN
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
`endif

  logic             sub;
  logic             arith;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             v;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] acc_n;

  // SUB and SLT share the a + ~b + 1 adder path; v is the signed overflow of that sum
  always_comb begin
    sub   = bus.op == OP_SUB || bus.op == OP_SLT;
    arith = bus.op == OP_ADD || bus.op == OP_SUB;
    bx    = sub ? ~bus.b : bus.b;
    sum   = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    v     = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    res   = bus.op == OP_AND ? bus.a & bus.b :
            bus.op == OP_OR  ? bus.a | bus.b :
            arith            ? sum[WIDTH-1:0] :
            bus.op == OP_SLT ? {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v} : '0;
    acc_n = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef ALU_FLAGS_EN
    zero_d   = zero_q;
    ovf_d    = ovf_q;
`endif
    if (state_q == S_IDLE && bus.in_valid) begin
      if (bus.op == OP_MUL) begin
        state_d  = S_MUL;
        acc_d    = '0;
        mcand_d  = bus.a;
        mplier_d = bus.b;
        cnt_d    = '0;
      end else begin
        state_d  = S_DONE;
        r_d      = res;
        c_d      = arith & sum[WIDTH];
`ifdef ALU_FLAGS_EN
        zero_d   = res == '0;
        ovf_d    = arith & v;
`endif
      end
    end else if (state_q == S_MUL) begin
      acc_d    = acc_n;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = S_DONE;
        r_d     = acc_n;
        c_d     = 1'b0;
`ifdef ALU_FLAGS_EN
        zero_d  = acc_n == '0;
        ovf_d   = 1'b0;
`endif
      end
    end else if (state_q == S_DONE && bus.out_ready) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      r_q      <= '0;
      c_q      <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_FLAGS_EN
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef ALU_FLAGS_EN
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.out_valid = state_q == S_DONE;
  assign bus.r         = r_q;
  assign bus.c_out     = c_q;
`ifdef ALU_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
`endif
endmodule
